// File: rtl/kf8259_seq_pkg.sv
// Shared types and constants for the 8259 interrupt-acknowledge sequencer.
// Used by kf8259_inta_sequencer and kf8259_seq_phase_timer.
package kf8259_seq_pkg;

  typedef enum logic [2:0] {
    ACK_IDLE,
    ACK_INTA1,
    ACK_GAP,
    ACK_INTA2,
    ACK_DONE
  } ack_state_t;

  typedef enum logic [1:0] {
    INIT_START,
    INIT_WRITE,
    INIT_RECOVER,
    INIT_COMPLETE
  } init_state_t;

  typedef enum logic [1:0] {
    IDX_ICW1,
    IDX_ICW2,
    IDX_ICW4,
    IDX_OCW1
  } init_idx_t;

  localparam logic       A0_CMD          = 1'b0;
  localparam logic       A0_DATA         = 1'b1;
  localparam logic [7:0] SPURIOUS_VECTOR = 8'hFF;

  // The longest phase is either an INTA# pulse, the gap, or the 3-clock init write.
  function automatic int timer_width(input int low_cycles, input int gap_cycles);
    int m;
    m = 32'sd3;
    if (low_cycles > m) m = low_cycles;
    if (gap_cycles > m) m = gap_cycles;
    return $clog2(m) + 32'sd1;
  endfunction

endpackage

// File: rtl/kf8259_inta_sequencer_if.sv
// CPU-side handshake and PIC-side bus of the INTA sequencer.
// master = the sequencer, slave = the CPU interrupt unit plus PIC.
interface kf8259_inta_sequencer_if;
  logic        cpu_ack_req;
  logic        cpu_ack_done;
  logic [7:0]  cpu_vector;
  logic        cpu_ack_spurious;
  logic        cpu_intr;
  logic        init_done;
  logic        pic_interrupt;
  logic        pic_inta_n;
  logic [15:0] pic_data_in;
  logic        pic_data_io;
  logic        pic_cs_n;
  logic        pic_wr_n;
  logic        pic_address;
  logic [15:0] pic_data_out;

  modport master (
    input  cpu_ack_req, pic_interrupt, pic_data_in, pic_data_io,
    output cpu_ack_done, cpu_vector, cpu_ack_spurious, cpu_intr, init_done,
           pic_inta_n, pic_cs_n, pic_wr_n, pic_address, pic_data_out
  );

  modport slave (
    output cpu_ack_req, pic_interrupt, pic_data_in, pic_data_io,
    input  cpu_ack_done, cpu_vector, cpu_ack_spurious, cpu_intr, init_done,
           pic_inta_n, pic_cs_n, pic_wr_n, pic_address, pic_data_out
  );
endinterface

// File: rtl/kf8259_seq_phase_timer.sv
// Load/count/expire down-counter timing every phase of the ACK and INIT sequences.
// A phase of N clocks is timed by loading N-1; expired is high on its last clock.
module kf8259_seq_phase_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;

  // Count down to zero and hold there until the next load.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/kf8259_inta_sequencer.sv
// Drives the two INTA# cycles of an 8259 PIC and returns the vector to the CPU.
// Optional post-reset PIC programming is built when KF8259_SEQ_INIT_EN is defined.
module kf8259_inta_sequencer
  import kf8259_seq_pkg::*;
#(
  parameter int         INTA_LOW_CYCLES = 2,
  parameter int         INTA_GAP_CYCLES = 2,
  parameter logic [7:0] ICW1            = 8'h13,
  parameter logic [7:0] ICW2            = 8'h08,
  parameter logic [7:0] ICW4            = 8'h01,
  parameter logic [7:0] OCW1            = 8'h00
) (
  input logic                      clock,
  input logic                      reset_n,
  kf8259_inta_sequencer_if.master  bus
);

  localparam int            TW       = timer_width(INTA_LOW_CYCLES, INTA_GAP_CYCLES);
  localparam logic [TW-1:0] LOW_LOAD = TW'(INTA_LOW_CYCLES - 32'sd1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(INTA_GAP_CYCLES - 32'sd1);

  ack_state_t    ack_state_r, ack_next_s;
  logic          ack_load_s;
  logic [TW-1:0] ack_value_s;
  logic          capture_s;
  logic          timer_load_s;
  logic [TW-1:0] timer_value_s;
  logic          timer_expired_s;
  logic          init_done_r;
  logic          inta_n_r;
  logic          ack_done_r;
  logic [7:0]    vector_r;
  logic          spurious_r;
  logic          unused_data_s;

  kf8259_seq_phase_timer #(.WIDTH(TW)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (timer_load_s),
    .load_value (timer_value_s),
    .expired    (timer_expired_s)
  );

  // ACK sequence next-state and timer requests.
  always_comb begin
    ack_next_s  = ack_state_r;
    ack_load_s  = 1'b0;
    ack_value_s = LOW_LOAD;
    capture_s   = 1'b0;
    case (ack_state_r)
      ACK_IDLE: begin
        if (bus.cpu_ack_req && init_done_r) begin
          ack_next_s = ACK_INTA1;
          ack_load_s = 1'b1;
        end else begin
          ack_next_s = ACK_IDLE;
        end
      end
      ACK_INTA1: begin
        if (timer_expired_s) begin
          ack_next_s  = ACK_GAP;
          ack_load_s  = 1'b1;
          ack_value_s = GAP_LOAD;
        end else begin
          ack_next_s = ACK_INTA1;
        end
      end
      ACK_GAP: begin
        if (timer_expired_s) begin
          ack_next_s = ACK_INTA2;
          ack_load_s = 1'b1;
        end else begin
          ack_next_s = ACK_GAP;
        end
      end
      ACK_INTA2: begin
        if (timer_expired_s) begin
          ack_next_s = ACK_DONE;
          capture_s  = 1'b1;
        end else begin
          ack_next_s = ACK_INTA2;
        end
      end
      ACK_DONE: ack_next_s = ACK_IDLE;
      default:  ack_next_s = ACK_IDLE;
    endcase
  end

  // ACK state register; outputs are registered from the next state so they align with it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ack_state_r <= ACK_IDLE;
      inta_n_r    <= 1'b1;
      ack_done_r  <= 1'b0;
      vector_r    <= 8'h00;
      spurious_r  <= 1'b0;
    end else begin
      ack_state_r <= ack_next_s;
      inta_n_r    <= !((ack_next_s == ACK_INTA1) || (ack_next_s == ACK_INTA2));
      ack_done_r  <= (ack_next_s == ACK_DONE);
      if (capture_s) begin
        if (!bus.pic_data_io) begin
          vector_r   <= bus.pic_data_in[7:0];
          spurious_r <= 1'b0;
        end else begin
          vector_r   <= SPURIOUS_VECTOR;
          spurious_r <= 1'b1;
        end
      end else begin
        vector_r   <= vector_r;
        spurious_r <= spurious_r;
      end
    end
  end

`ifdef KF8259_SEQ_INIT_EN
  localparam logic [TW-1:0] WRITE_LOAD   = TW'(32'sd1);
  localparam logic [TW-1:0] RECOVER_LOAD = TW'(32'sd0);

  init_state_t   init_state_r, init_next_s;
  init_idx_t     init_idx_r, init_idx_next_s;
  logic          init_load_s;
  logic [TW-1:0] init_value_s;
  logic          cs_n_r;
  logic          wr_n_r;
  logic          address_r;
  logic [15:0]   data_out_r;

  function automatic logic [7:0] init_word(input init_idx_t idx);
    case (idx)
      IDX_ICW1: return ICW1;
      IDX_ICW2: return ICW2;
      IDX_ICW4: return ICW4;
      IDX_OCW1: return OCW1;
      default:  return OCW1;
    endcase
  endfunction

  // ICW4 is only sent when ICW1 announces it.
  function automatic init_idx_t init_follow(input init_idx_t idx);
    case (idx)
      IDX_ICW1: return IDX_ICW2;
      IDX_ICW2: return ICW1[0] ? IDX_ICW4 : IDX_OCW1;
      IDX_ICW4: return IDX_OCW1;
      IDX_OCW1: return IDX_OCW1;
      default:  return IDX_OCW1;
    endcase
  endfunction

  // INIT sequence: 2-clock write strobe then 1 recovery clock per word.
  always_comb begin
    init_next_s     = init_state_r;
    init_idx_next_s = init_idx_r;
    init_load_s     = 1'b0;
    init_value_s    = WRITE_LOAD;
    case (init_state_r)
      INIT_START: begin
        init_next_s     = INIT_WRITE;
        init_idx_next_s = IDX_ICW1;
        init_load_s     = 1'b1;
      end
      INIT_WRITE: begin
        if (timer_expired_s) begin
          init_next_s  = INIT_RECOVER;
          init_load_s  = 1'b1;
          init_value_s = RECOVER_LOAD;
        end else begin
          init_next_s = INIT_WRITE;
        end
      end
      INIT_RECOVER: begin
        if (timer_expired_s && (init_idx_r == IDX_OCW1)) begin
          init_next_s = INIT_COMPLETE;
        end else if (timer_expired_s) begin
          init_next_s     = INIT_WRITE;
          init_idx_next_s = init_follow(init_idx_r);
          init_load_s     = 1'b1;
        end else begin
          init_next_s = INIT_RECOVER;
        end
      end
      INIT_COMPLETE: init_next_s = INIT_COMPLETE;
      default:       init_next_s = INIT_START;
    endcase
  end

  // INIT state register and registered PIC write bus.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      init_state_r <= INIT_START;
      init_idx_r   <= IDX_ICW1;
      cs_n_r       <= 1'b1;
      wr_n_r       <= 1'b1;
      address_r    <= 1'b0;
      data_out_r   <= 16'h0000;
      init_done_r  <= 1'b0;
    end else begin
      init_state_r <= init_next_s;
      init_idx_r   <= init_idx_next_s;
      cs_n_r       <= (init_next_s != INIT_WRITE);
      wr_n_r       <= (init_next_s != INIT_WRITE);
      init_done_r  <= (init_next_s == INIT_COMPLETE);
      if ((init_next_s == INIT_WRITE) || (init_next_s == INIT_RECOVER)) begin
        address_r  <= (init_idx_next_s == IDX_ICW1) ? A0_CMD : A0_DATA;
        data_out_r <= {8'h00, init_word(init_idx_next_s)};
      end else begin
        address_r  <= 1'b0;
        data_out_r <= 16'h0000;
      end
    end
  end

  assign timer_load_s     = init_load_s | ack_load_s;
  assign timer_value_s    = init_load_s ? init_value_s : ack_value_s;
  assign bus.pic_cs_n     = cs_n_r;
  assign bus.pic_wr_n     = wr_n_r;
  assign bus.pic_address  = address_r;
  assign bus.pic_data_out = data_out_r;
`else
  logic unused_init_cfg_s;

  // Without PIC programming the block is ready one clock after reset is released.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      init_done_r <= 1'b0;
    end else begin
      init_done_r <= 1'b1;
    end
  end

  assign timer_load_s      = ack_load_s;
  assign timer_value_s     = ack_value_s;
  assign bus.pic_cs_n      = 1'b1;
  assign bus.pic_wr_n      = 1'b1;
  assign bus.pic_address   = 1'b0;
  assign bus.pic_data_out  = 16'h0000;
  assign unused_init_cfg_s = ^{ICW1, ICW2, ICW4, OCW1, A0_CMD, A0_DATA};
`endif

  assign unused_data_s        = ^bus.pic_data_in[15:8];
  assign bus.cpu_ack_done     = ack_done_r;
  assign bus.cpu_vector       = vector_r;
  assign bus.cpu_ack_spurious = spurious_r;
  assign bus.pic_inta_n       = inta_n_r;
  assign bus.init_done        = init_done_r;
  assign bus.cpu_intr         = bus.pic_interrupt & init_done_r;

endmodule

// File: tb/tb_kf8259_inta_sequencer.sv
// Randomized scoreboard bench for kf8259_inta_sequencer (KF8259_SEQ_INIT_EN on or off).
// A cycle-level reference model predicts INTA#, done, vector and init writes.
module tb_kf8259_inta_sequencer;

  localparam int         L       = 2;
  localparam int         G       = 2;
  localparam int         DLAT    = 2 * L + G;
  localparam logic [7:0] TB_ICW1 = 8'h13;
  localparam logic [7:0] TB_ICW2 = 8'h08;
  localparam logic [7:0] TB_ICW4 = 8'h01;
  localparam logic [7:0] TB_OCW1 = 8'hFC;
`ifdef KF8259_SEQ_INIT_EN
  localparam int NW = TB_ICW1[0] ? 4 : 3;
`else
  localparam int NW = 0;
`endif

  typedef struct {
    logic [7:0] vec;
    logic       sp;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  int         cyc = 0;
  int         init_base = -1;
  bit         exp_init_done = 1'b0;
  bit         started = 1'b0;
  int         start = 0;
  int         last_done = -100;
  logic [7:0] hold_vec = 8'h00;
  logic       hold_sp = 1'b0;
  exp_t       sb[$];

  kf8259_inta_sequencer_if bus();

  kf8259_inta_sequencer #(
    .INTA_LOW_CYCLES (L),
    .INTA_GAP_CYCLES (G),
    .ICW1            (TB_ICW1),
    .ICW2            (TB_ICW2),
    .ICW4            (TB_ICW4),
    .OCW1            (TB_OCW1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Init write w as {A0, data}: ICW1 to A0=0, then ICW2, optional ICW4, OCW1 to A0=1.
  function automatic logic [8:0] init_write(input int w);
    if (w == 0) return {1'b0, TB_ICW1};
    if (w == 1) return {1'b1, TB_ICW2};
    if (w == 2 && NW == 4) return {1'b1, TB_ICW4};
    return {1'b1, TB_OCW1};
  endfunction

  // Reference model: acceptance, vector sampling and init_done timing.
  always @(posedge clock) begin : model
    int   cyc_new;
    exp_t e;
    cyc_new = cyc + 1;
    if (!reset_n) begin
      init_base     = -1;
      exp_init_done = 1'b0;
      started       = 1'b0;
      last_done     = -100;
      hold_vec      = 8'h00;
      hold_sp       = 1'b0;
      sb.delete();
    end else begin
      if (init_base < 0) init_base = cyc_new;
      if (started && cyc_new == start + DLAT) begin
        if (bus.pic_data_io == 1'b0) begin
          e.vec = bus.pic_data_in[7:0];
          e.sp  = 1'b0;
        end else begin
          e.vec = 8'hFF;
          e.sp  = 1'b1;
        end
        sb.push_back(e);
        hold_vec = e.vec;
        hold_sp  = e.sp;
      end
      if (bus.cpu_ack_req && exp_init_done && cyc_new >= last_done + 2) begin
        started   = 1'b1;
        start     = cyc_new;
        last_done = cyc_new + DLAT;
      end
      exp_init_done = (cyc_new - init_base) >= 3 * NW;
    end
    cyc = cyc_new;
  end

  // Monitor: compares every DUT output against the model once per cycle.
  always @(negedge clock) begin : monitor
    int         d;
    int         di;
    logic       exp_inta;
    logic       exp_done;
    logic [8:0] w;
    exp_t       e;
    if (mon_en) begin
      d        = cyc - start;
      exp_inta = 1'b1;
      exp_done = 1'b0;
      if (started && d >= 0 && d <= DLAT) begin
        if (d < L || (d >= L + G && d < DLAT)) exp_inta = 1'b0;
        if (d == DLAT) exp_done = 1'b1;
      end
      check("inta_n", 16'(bus.pic_inta_n), 16'(exp_inta));
      check("ack_done", 16'(bus.cpu_ack_done), 16'(exp_done));
      if (bus.cpu_ack_done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_empty actual=done_pulse expected=no_pulse cycle=%0d", cyc);
        end else begin
          e = sb.pop_front();
          check("vector", 16'(bus.cpu_vector), 16'(e.vec));
          check("spurious", 16'(bus.cpu_ack_spurious), 16'(e.sp));
        end
      end else begin
        check("vector_hold", 16'(bus.cpu_vector), 16'(hold_vec));
        check("spurious_hold", 16'(bus.cpu_ack_spurious), 16'(hold_sp));
      end
      check("init_done", 16'(bus.init_done), 16'(exp_init_done));
      check("cpu_intr", 16'(bus.cpu_intr), 16'(bus.pic_interrupt & exp_init_done));
      if (init_base >= 0 && (cyc - init_base) < 3 * NW) begin
        di = cyc - init_base;
        w  = init_write(di / 3);
        check("init_cs_n", 16'(bus.pic_cs_n), 16'((di % 3) == 2));
        check("init_wr_n", 16'(bus.pic_wr_n), 16'((di % 3) == 2));
        check("init_a0", 16'(bus.pic_address), 16'(w[8]));
        check("init_data", bus.pic_data_out, {8'h00, w[7:0]});
      end else begin
        check("cs_n_idle", 16'(bus.pic_cs_n), 16'd1);
        check("wr_n_idle", 16'(bus.pic_wr_n), 16'd1);
      end
    end
  end

  task automatic check_reset();
    check("rst_inta_n", 16'(bus.pic_inta_n), 16'd1);
    check("rst_cs_n", 16'(bus.pic_cs_n), 16'd1);
    check("rst_wr_n", 16'(bus.pic_wr_n), 16'd1);
    check("rst_a0", 16'(bus.pic_address), 16'd0);
    check("rst_data_out", bus.pic_data_out, 16'h0000);
    check("rst_done", 16'(bus.cpu_ack_done), 16'd0);
    check("rst_vector", 16'(bus.cpu_vector), 16'h0000);
    check("rst_spurious", 16'(bus.cpu_ack_spurious), 16'd0);
    check("rst_init_done", 16'(bus.init_done), 16'd0);
  endtask

  task automatic drive_random();
    bus.pic_data_in   = 16'($urandom);
    bus.pic_data_io   = ($urandom_range(0, 3) == 0);
    bus.pic_interrupt = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_random();
      @(posedge clock);
      #2;
    end
  endtask

  // mode 0: random bus, 1: PIC drives 8'h0A, 2: PIC never drives. Returns the done cycle.
  task automatic do_txn(input bit hold, input int mode, input bit check_lat, output int done_cyc);
    bit got;
    int raise_cyc;
    got       = 1'b0;
    raise_cyc = cyc;
    done_cyc  = -1;
    bus.cpu_ack_req = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      drive_random();
      if (mode == 1) begin
        bus.pic_data_in = 16'h000A;
        bus.pic_data_io = 1'b0;
      end else if (mode == 2) begin
        bus.pic_data_io = 1'b1;
      end
      @(posedge clock);
      #2;
      if (bus.cpu_ack_done === 1'b1) begin
        got      = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!hold) bus.cpu_ack_req = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL txn_timeout actual=no_done expected=done_within_200_cycles");
    end else begin
      if (check_lat) check("latency", 16'(cyc - raise_cyc), 16'(DLAT + 1));
      if (mode == 1) begin
        check("directed_vector", 16'(bus.cpu_vector), 16'h000A);
        check("directed_spurious", 16'(bus.cpu_ack_spurious), 16'd0);
      end else if (mode == 2) begin
        check("spurious_vector", 16'(bus.cpu_vector), 16'h00FF);
        check("spurious_flag", 16'(bus.cpu_ack_spurious), 16'd1);
      end
    end
  endtask

  initial begin : stimulus
    int d1;
    int d2;
    bus.cpu_ack_req   = 1'b0;
    bus.pic_data_in   = 16'h0000;
    bus.pic_data_io   = 1'b1;
    bus.pic_interrupt = 1'b0;
    reset_n           = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check_reset();
    mon_en  = 1'b1;
    reset_n = 1'b1;

    // Request raised straight out of reset: serviced only once init_done is up.
    do_txn(1'b0, 0, 1'b0, d1);
    idle_cycles(2);
    do_txn(1'b0, 1, 1'b1, d1);
    idle_cycles(1);
    do_txn(1'b0, 2, 1'b1, d1);
    idle_cycles(1);

    // Request held through DONE: next sequence restarts after one idle cycle.
    do_txn(1'b1, 0, 1'b0, d1);
    do_txn(1'b0, 0, 1'b0, d2);
    check("back_to_back_gap", 16'(d2 - d1), 16'(DLAT + 2));

    // Reset during GAP aborts the sequence with no done pulse.
    idle_cycles(1);
    bus.cpu_ack_req = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b0;
    bus.cpu_ack_req = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check_reset();
    reset_n = 1'b1;
    idle_cycles(3);

    for (int t = 0; t < 40; t++) begin
      idle_cycles($urandom_range(0, 3));
      do_txn($urandom_range(0, 3) == 0, 0, 1'b0, d1);
    end
    bus.cpu_ack_req = 1'b0;
    idle_cycles(DLAT + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
